est_engine: RTL and testbench
=============================

EST_ENGINE -- requirements
Module: est_engine

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, signed sample/weight width.
REQ-002 SHALL have parameter FRAC_BITS, default 12, fixed-point fraction bits of Z, W and S (Q(DATA_WIDTH-FRAC_BITS).FRAC_BITS).
REQ-003 SHALL have parameter DIM, default 3, number of signals/components (2..8).
REQ-004 SHALL have parameter SAMPLES, default 4, number of samples per frame (1..64).
REQ-005 SHALL have port clk  input  1  rising-edge clock; one clock; reset is asynchronous and active-high.
REQ-006 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-007 SHALL have port start  input  1  request a frame; honoured only in IDLE.
REQ-008 SHALL have port abort  input  1  cancel the frame in progress.
REQ-009 SHALL have port z_in  input  DATA_WIDTH*DIM*SAMPLES  whitened data; element [i][s] at flat index i*SAMPLES+s, index 0 at MSB end.
REQ-010 SHALL have port w_mat  input  DATA_WIDTH*DIM*DIM  unmixing matrix; element [i][k] at flat index i*DIM+k.
REQ-011 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-012 SHALL have port done  output  1  one-cycle frame-complete pulse.
REQ-013 SHALL have port s_est  output  DATA_WIDTH*DIM*SAMPLES  estimated sources; element [k][s] at flat index k*SAMPLES+s.

Function
REQ-014 SHALL compute s_est[k][s] = round(sum over i of w_mat[i][k]*z_in[i][s] >> FRAC_BITS), i.e. column k of W dotted with column s of Z.
REQ-015 SHALL snapshot z_in and w_mat into internal registers on the edge where start=1 in IDLE; inputs may change afterwards.
REQ-016 SHALL implement states IDLE, MAC, STORE, DONE: IDLE -start-> MAC; MAC stays DIM cycles (one product per cycle, i=0..DIM-1) then -> STORE; STORE -> MAC for next element or -> DONE after element [DIM-1][SAMPLES-1]; DONE -> IDLE.
REQ-017 SHALL order elements s-inner, k-outer ([0][0],[0][1],...,[DIM-1][SAMPLES-1]).
REQ-018 SHALL hold the accumulator at ACC_WIDTH = 2*DATA_WIDTH + clog2(DIM) bits, cleared on entry to each element; no intermediate truncation.
REQ-019 SHALL round half-up (add 2^(FRAC_BITS-1) before arithmetic right shift) in STORE.
REQ-020 SHALL write each element of s_est only in its STORE cycle; other elements hold.
REQ-021 SHALL assert done for exactly the DONE cycle; done high occurs DIM*SAMPLES*(DIM+1)+1 edges after the start edge (49 at defaults).
REQ-022 SHALL ignore start while busy.
REQ-023 SHALL, on abort=1 in any non-IDLE state, go to IDLE on the next edge, suppress done, leave already-stored s_est elements unchanged; abort has priority over start in the same cycle; abort in IDLE is a no-op.

Reset
REQ-024 SHALL on rst force state IDLE, busy=0, done=0, s_est all zero, accumulator and counters zero, asynchronously and independent of clk.
REQ-025 SHALL, if rst asserts mid-frame, discard the frame with no done pulse.

Configuration
REQ-026 SHALL honour macro EST_ENGINE_SATURATE_EN: defined -> rounded result clamped to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]; undefined -> low DATA_WIDTH bits kept (two's-complement wrap).

Structure
REQ-027 SHALL place the state enumeration, the ACC_WIDTH function and the Q-format constants in shared package est_pkg.
REQ-028 SHALL implement multiply-accumulate, rounding and saturation in sub-module est_mac (clear, enable, a, b inputs; acc and rounded result outputs).

Verification
REQ-029 SHALL cover identity: W=I (diagonal 4096), Z arbitrary -> s_est equals z_in, done at edge 49.
REQ-030 SHALL cover scaling: W=0.5*I (2048), z[i][s]=3 -> s_est=2 (1.5 rounds half-up).
REQ-031 SHALL cover overflow: all W=all Z=32767 -> with EST_ENGINE_SATURATE_EN s_est=32767 everywhere; without, wrapped low 16 bits of the rounded sum.
REQ-032 SHALL cover abort at cycle 10 after start -> no done, busy low next cycle, elements [0][0],[0][1] stored, rest unchanged from prior values.
REQ-033 SHALL cover start pulsed while busy and input change after start -> ignored; results match snapshot values.
REQ-034 SHALL cover rst asserted mid-frame without clock edge -> busy=0, s_est=0 immediately, no done.

Source files
------------

// File: rtl/est_pkg.sv
// Shared state encoding, accumulator sizing and Q-format constants for the
// source-estimation engine.
package est_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_MAC   = 2'd1,
      ST_STORE = 2'd2,
      ST_DONE  = 2'd3
   } est_state_e;

   localparam int EST_DATA_WIDTH = 16;
   localparam int EST_FRAC_BITS  = 12;
   localparam int EST_INT_BITS   = EST_DATA_WIDTH - EST_FRAC_BITS;

   // Full-precision sum of dim products of two dw-bit signed values.
   function automatic int acc_width(input int dw, input int dim);
      return 2 * dw + $clog2(dim);
   endfunction

endpackage

// File: rtl/est_mac.sv
// Multiply-accumulate lane with half-up rounding of the accumulator.
// Build option: EST_ENGINE_SATURATE_EN clamps the rounded result instead of wrapping.
module est_mac
   import est_pkg::*;
#(
   parameter int DATA_WIDTH = EST_DATA_WIDTH,
   parameter int FRAC_BITS  = EST_FRAC_BITS,
   parameter int ACC_WIDTH  = acc_width(EST_DATA_WIDTH, 3)
)(
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         clear,
   input  logic                         en,
   input  logic signed [DATA_WIDTH-1:0] a,
   input  logic signed [DATA_WIDTH-1:0] b,
   output logic signed [ACC_WIDTH-1:0]  acc,
   output logic        [DATA_WIDTH-1:0] res
);

   localparam logic signed [ACC_WIDTH:0] RND_HALF =
      {{ACC_WIDTH{1'b0}}, 1'b1} << (FRAC_BITS - 1);
   localparam logic signed [ACC_WIDTH:0] SAT_MAX =
      {{(ACC_WIDTH - DATA_WIDTH + 2){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
   localparam logic signed [ACC_WIDTH:0] SAT_MIN = ~SAT_MAX;

   logic signed [ACC_WIDTH-1:0]    acc_q, acc_d;
   logic signed [2*DATA_WIDTH-1:0] prod;
   logic signed [ACC_WIDTH:0]      rnd_sum, rnd_val;

   always_comb begin
      prod  = a * b;
      acc_d = acc_q;
      if (clear)
         acc_d = '0;
      else if (en)
         acc_d = acc_q + {{(ACC_WIDTH - 2*DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) acc_q <= '0;
      else     acc_q <= acc_d;
   end

   // One guard bit keeps the rounding add from overflowing at full-scale sums.
   always_comb begin
      rnd_sum = {acc_q[ACC_WIDTH-1], acc_q} + RND_HALF;
      rnd_val = rnd_sum >>> FRAC_BITS;
`ifdef EST_ENGINE_SATURATE_EN
      if (rnd_val > SAT_MAX)
         res = SAT_MAX[DATA_WIDTH-1:0];
      else if (rnd_val < SAT_MIN)
         res = SAT_MIN[DATA_WIDTH-1:0];
      else
         res = rnd_val[DATA_WIDTH-1:0];
`else
      res = rnd_val[DATA_WIDTH-1:0];
`endif
   end

   assign acc = acc_q;

endmodule

// File: rtl/est_engine.sv
// Source estimator: S = W^T * Z in fixed point, one MAC per cycle, one output element per DIM+1 cycles.
// Build option: EST_ENGINE_SATURATE_EN selects clamping of each output element.
module est_engine
   import est_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int FRAC_BITS  = 12,
   parameter int DIM        = 3,
   parameter int SAMPLES    = 4
)(
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  start,
   input  logic                                  abort,
   input  logic [DATA_WIDTH*DIM*SAMPLES-1:0]     z_in,
   input  logic [DATA_WIDTH*DIM*DIM-1:0]         w_mat,
   output logic                                  busy,
   output logic                                  done,
   output logic [DATA_WIDTH*DIM*SAMPLES-1:0]     s_est
);

   localparam int ACC_WIDTH = acc_width(DATA_WIDTH, DIM);
   localparam int NZ        = DIM * SAMPLES;
   localparam int NW        = DIM * DIM;
   localparam int IW        = $clog2(DIM);
   localparam int SW        = (SAMPLES > 1) ? $clog2(SAMPLES) : 1;
   localparam int ZIW       = $clog2(NZ);
   localparam int WIW       = $clog2(NW);

   est_state_e state_q, state_d;
   logic [IW-1:0] i_q, i_d, k_q, k_d;
   logic [SW-1:0] s_q, s_d;

   logic signed [DATA_WIDTH-1:0] z_q [NZ];
   logic signed [DATA_WIDTH-1:0] z_d [NZ];
   logic signed [DATA_WIDTH-1:0] w_q [NW];
   logic signed [DATA_WIDTH-1:0] w_d [NW];
   logic        [DATA_WIDTH-1:0] out_q [NZ];
   logic        [DATA_WIDTH-1:0] out_d [NZ];
   logic signed [DATA_WIDTH-1:0] z_unp [NZ];
   logic signed [DATA_WIDTH-1:0] w_unp [NW];

   logic                         mac_clr, mac_en, snap, st_wr;
   logic        [ZIW-1:0]        z_idx, o_idx;
   logic        [WIW-1:0]        w_idx;
   logic signed [DATA_WIDTH-1:0] mac_a, mac_b;
   logic signed [ACC_WIDTH-1:0]  mac_acc;
   logic        [DATA_WIDTH-1:0] mac_res;

   // Flat buses carry element 0 at the MSB end.
   for (genvar e = 0; e < NZ; e++) begin : g_z
      assign z_unp[e] = z_in[(NZ-1-e)*DATA_WIDTH +: DATA_WIDTH];
      assign s_est[(NZ-1-e)*DATA_WIDTH +: DATA_WIDTH] = out_q[e];
   end
   for (genvar e = 0; e < NW; e++) begin : g_w
      assign w_unp[e] = w_mat[(NW-1-e)*DATA_WIDTH +: DATA_WIDTH];
   end

   always_comb begin
      state_d = state_q;
      i_d     = i_q;
      s_d     = s_q;
      k_d     = k_q;
      mac_clr = 1'b0;
      mac_en  = 1'b0;
      snap    = 1'b0;
      st_wr   = 1'b0;
      case (state_q)
         ST_IDLE: if (start) begin
            state_d = ST_MAC;
            i_d     = '0;
            s_d     = '0;
            k_d     = '0;
            mac_clr = 1'b1;
            snap    = 1'b1;
         end
         ST_MAC: begin
            mac_en = 1'b1;
            if (i_q == IW'(DIM - 1)) begin
               i_d     = '0;
               state_d = ST_STORE;
            end else begin
               i_d = i_q + 1'b1;
            end
         end
         ST_STORE: begin
            st_wr   = 1'b1;
            mac_clr = 1'b1;
            state_d = ST_MAC;
            if (s_q == SW'(SAMPLES - 1)) begin
               s_d = '0;
               if (k_q == IW'(DIM - 1)) state_d = ST_DONE;
               else                     k_d     = k_q + 1'b1;
            end else begin
               s_d = s_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // Abort drops the frame: no further products, no further stores.
      if (abort && state_q != ST_IDLE) begin
         state_d = ST_IDLE;
         mac_en  = 1'b0;
         st_wr   = 1'b0;
         mac_clr = 1'b1;
      end
   end

   always_comb begin
      z_idx = ZIW'(int'(i_q) * SAMPLES + int'(s_q));
      w_idx = WIW'(int'(i_q) * DIM + int'(k_q));
      o_idx = ZIW'(int'(k_q) * SAMPLES + int'(s_q));
      mac_a = w_q[w_idx];
      mac_b = z_q[z_idx];
      z_d   = snap ? z_unp : z_q;
      w_d   = snap ? w_unp : w_q;
      out_d = out_q;
      if (st_wr) out_d[o_idx] = mac_res;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         i_q     <= '0;
         s_q     <= '0;
         k_q     <= '0;
         for (int e = 0; e < NZ; e++) begin
            z_q[e]   <= '0;
            out_q[e] <= '0;
         end
         for (int e = 0; e < NW; e++) w_q[e] <= '0;
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         s_q     <= s_d;
         k_q     <= k_d;
         z_q     <= z_d;
         w_q     <= w_d;
         out_q   <= out_d;
      end
   end

   est_mac #(
      .DATA_WIDTH (DATA_WIDTH),
      .FRAC_BITS  (FRAC_BITS),
      .ACC_WIDTH  (ACC_WIDTH)
   ) u_mac (
      .clk   (clk),
      .rst   (rst),
      .clear (mac_clr),
      .en    (mac_en),
      .a     (mac_a),
      .b     (mac_b),
      .acc   (mac_acc),
      .res   (mac_res)
   );

   assign busy = (state_q != ST_IDLE);
   assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_est_engine.sv
// Scoreboard bench for est_engine: expected elements are queued at start and
// popped when done is seen. Honours EST_ENGINE_SATURATE_EN in its model.
module tb_est_engine;

   localparam int DW  = 16;
   localparam int FB  = 12;
   localparam int DIM = 3;
   localparam int S   = 4;
   localparam int NZ  = DIM * S;
   localparam int NW  = DIM * DIM;
   // Edges from the start edge to the edge that enters DONE; the start edge
   // itself is the first of the DIM*S*(DIM+1)+1 edges.
   localparam int LAT = DIM * S * (DIM + 1);

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               start = 1'b0;
   logic               abort = 1'b0;
   logic [DW*NZ-1:0]   z_in = '0;
   logic [DW*NW-1:0]   w_mat = '0;
   logic               busy, done;
   logic [DW*NZ-1:0]   s_est;

   int              checks = 0;
   int              errors = 0;
   int              zm [DIM][S];
   int              wm [DIM][DIM];
   logic [DW-1:0]   exp_out [DIM][S];
   logic [DW-1:0]   sb [$];

   est_engine #(.DATA_WIDTH(DW), .FRAC_BITS(FB), .DIM(DIM), .SAMPLES(S)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .z_in(z_in), .w_mat(w_mat), .busy(busy), .done(done), .s_est(s_est)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] model(input int k, input int s);
      longint acc;
      logic [63:0] r;
      acc = 0;
      for (int i = 0; i < DIM; i++) acc += longint'(wm[i][k]) * longint'(zm[i][s]);
      acc = (acc + (64'sd1 <<< (FB - 1))) >>> FB;
`ifdef EST_ENGINE_SATURATE_EN
      if (acc > 32767) acc = 32767;
      if (acc < -32768) acc = -32768;
`endif
      r = acc;
      return r[DW-1:0];
   endfunction

   function automatic logic [DW-1:0] got_el(input int k, input int s);
      return s_est[(NZ-1-(k*S+s))*DW +: DW];
   endfunction

   task automatic drive_inputs();
      for (int i = 0; i < DIM; i++) begin
         for (int s = 0; s < S; s++) z_in[(NZ-1-(i*S+s))*DW +: DW] = zm[i][s][DW-1:0];
         for (int k = 0; k < DIM; k++) w_mat[(NW-1-(i*DIM+k))*DW +: DW] = wm[i][k][DW-1:0];
      end
   endtask

   // Drives inputs and a one-cycle start; returns at start edge + #1.
   task automatic launch(input bit push);
      drive_inputs();
      if (push)
         for (int k = 0; k < DIM; k++)
            for (int s = 0; s < S; s++) sb.push_back(model(k, s));
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(output int n, output bit seen);
      n = 0;
      seen = 1'b0;
      while (!seen && n < 200) begin
         @(posedge clk); #1;
         n++;
         if (done) seen = 1'b1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", done); end
      checks++;
      if (s_est !== '0) begin errors++; $display("FAIL reset_s_est got %h want 0", s_est); end
      rst = 1'b0;
      for (int k = 0; k < DIM; k++) for (int s = 0; s < S; s++) exp_out[k][s] = '0;
      @(posedge clk); #1;
   endtask

   task automatic test_identity();
      int n; bit seen; logic [DW-1:0] e;
      for (int i = 0; i < DIM; i++) begin
         for (int s = 0; s < S; s++) zm[i][s] = int'($urandom_range(0, 65535)) - 32768;
         for (int k = 0; k < DIM; k++) wm[i][k] = (i == k) ? 4096 : 0;
      end
      launch(1'b1);
      wait_done(n, seen);
      checks++;
      if (!seen || n != LAT) begin errors++; $display("FAIL identity_latency got %0d seen %0b want %0d", n, seen, LAT); end
      for (int k = 0; k < DIM; k++)
         for (int s = 0; s < S; s++) begin
            e = sb.pop_front();
            checks++;
            if (got_el(k, s) !== e || e !== zm[k][s][DW-1:0]) begin
               errors++; $display("FAIL identity[%0d][%0d] got %h want %h", k, s, got_el(k, s), zm[k][s][DW-1:0]);
            end
            exp_out[k][s] = e;
         end
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL identity_done_pulse got done %0b busy %0b want 0 0", done, busy); end
   endtask

   task automatic test_scaling();
      int n; bit seen; logic [DW-1:0] e;
      for (int i = 0; i < DIM; i++) begin
         for (int s = 0; s < S; s++) zm[i][s] = 3;
         for (int k = 0; k < DIM; k++) wm[i][k] = (i == k) ? 2048 : 0;
      end
      launch(1'b1);
      wait_done(n, seen);
      checks++;
      if (!seen) begin errors++; $display("FAIL scaling_done got timeout want done"); end
      for (int k = 0; k < DIM; k++)
         for (int s = 0; s < S; s++) begin
            e = sb.pop_front();
            checks++;
            if (got_el(k, s) !== e || e !== 16'd2) begin
               errors++; $display("FAIL scaling[%0d][%0d] got %h want 0002", k, s, got_el(k, s));
            end
            exp_out[k][s] = e;
         end
      @(posedge clk); #1;
   endtask

   task automatic test_overflow();
      int n; bit seen; logic [DW-1:0] e;
      for (int i = 0; i < DIM; i++) begin
         for (int s = 0; s < S; s++) zm[i][s] = 32767;
         for (int k = 0; k < DIM; k++) wm[i][k] = 32767;
      end
      launch(1'b1);
      wait_done(n, seen);
      checks++;
      if (!seen) begin errors++; $display("FAIL overflow_done got timeout want done"); end
      for (int k = 0; k < DIM; k++)
         for (int s = 0; s < S; s++) begin
            e = sb.pop_front();
            checks++;
            if (got_el(k, s) !== e) begin
               errors++; $display("FAIL overflow[%0d][%0d] got %h want %h", k, s, got_el(k, s), e);
            end
            exp_out[k][s] = e;
         end
      @(posedge clk); #1;
   endtask

   task automatic test_abort();
      bit saw_done; logic [DW-1:0] e;
      for (int i = 0; i < DIM; i++) begin
         for (int s = 0; s < S; s++) zm[i][s] = 3;
         for (int k = 0; k < DIM; k++) wm[i][k] = (i == k) ? 2048 : 0;
      end
      // Elements [0][0] and [0][1] store at edges 4 and 8; abort lands on edge 10.
      for (int k = 0; k < DIM; k++)
         for (int s = 0; s < S; s++)
            sb.push_back((k == 0 && s < 2) ? model(k, s) : exp_out[k][s]);
      launch(1'b0);
      saw_done = 1'b0;
      repeat (9) begin @(posedge clk); #1; if (done) saw_done = 1'b1; end
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %0b want 0", busy); end
      repeat (60) begin @(posedge clk); #1; if (done) saw_done = 1'b1; end
      checks++;
      if (saw_done) begin errors++; $display("FAIL abort_no_done got done want none"); end
      for (int k = 0; k < DIM; k++)
         for (int s = 0; s < S; s++) begin
            e = sb.pop_front();
            checks++;
            if (got_el(k, s) !== e) begin
               errors++; $display("FAIL abort[%0d][%0d] got %h want %h", k, s, got_el(k, s), e);
            end
            exp_out[k][s] = e;
         end
   endtask

   task automatic test_back_to_back();
      int n; bit seen; logic [DW-1:0] e;
      for (int i = 0; i < DIM; i++) begin
         for (int s = 0; s < S; s++) zm[i][s] = (i + 1) * 1000 - s * 700;
         for (int k = 0; k < DIM; k++) wm[i][k] = (i * DIM + k) * 300 - 1200;
      end
      launch(1'b1);
      // Change inputs and re-request start mid-frame; both must be ignored.
      repeat (5) @(posedge clk);
      #1;
      for (int i = 0; i < DIM; i++) begin
         for (int s = 0; s < S; s++) zm[i][s] = -5000;
         for (int k = 0; k < DIM; k++) wm[i][k] = 7000;
      end
      drive_inputs();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(n, seen);
      n = n + 6;
      checks++;
      if (!seen || n != LAT) begin errors++; $display("FAIL busy_start_latency got %0d seen %0b want %0d", n, seen, LAT); end
      for (int k = 0; k < DIM; k++)
         for (int s = 0; s < S; s++) begin
            e = sb.pop_front();
            checks++;
            if (got_el(k, s) !== e) begin
               errors++; $display("FAIL snapshot[%0d][%0d] got %h want %h", k, s, got_el(k, s), e);
            end
            exp_out[k][s] = e;
         end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      bit saw_done;
      for (int i = 0; i < DIM; i++) begin
         for (int s = 0; s < S; s++) zm[i][s] = 1234 + s;
         for (int k = 0; k < DIM; k++) wm[i][k] = (i == k) ? 4096 : 0;
      end
      launch(1'b0);
      repeat (20) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %0b want 0", busy); end
      checks++;
      if (s_est !== '0) begin errors++; $display("FAIL rst_mid_s_est got %h want 0", s_est); end
      #4;
      rst = 1'b0;
      saw_done = 1'b0;
      repeat (60) begin @(posedge clk); #1; if (done || busy) saw_done = 1'b1; end
      checks++;
      if (saw_done) begin errors++; $display("FAIL rst_mid_no_done got activity want idle"); end
   endtask

   initial begin
      test_reset();
      test_identity();
      test_scaling();
      test_overflow();
      test_abort();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
